// File: rtl/pong_game_sequencer_if.sv
// Game-side signal bundle for the Pong sequencer: controller/frame/miss inputs
// and the ball-control, score and status outputs.
interface pong_game_sequencer_if;
    logic       frame_tick;
    logic       start_btn;
    logic       miss_left;
    logic       miss_right;
    logic       pause_btn;
    logic       ball_reset;
    logic       move_en;
    logic       serve_dir;
    logic [3:0] score_left;
    logic [3:0] score_right;
    logic       game_over;
    logic       winner;
    logic [2:0] seq_state;

    modport master (
        output frame_tick, start_btn, miss_left, miss_right, pause_btn,
        input  ball_reset, move_en, serve_dir, score_left, score_right,
               game_over, winner, seq_state
    );

    modport slave (
        input  frame_tick, start_btn, miss_left, miss_right, pause_btn,
        output ball_reset, move_en, serve_dir, score_left, score_right,
               game_over, winner, seq_state
    );
endinterface

// File: rtl/pong_game_sequencer.sv
// Pong match scheduler: serve hold, per-frame move enable, scoring and match end.
// Optional pause (pause_btn toggles a PAUSE state shown as seq_state 5) under `SEQ_PAUSE_EN.
module pong_game_sequencer #(
    parameter int unsigned WIN_SCORE    = 7,
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned POINT_FRAMES = 30,
    parameter int unsigned SPEED_DIV    = 1
) (
    input logic                  clk,
    input logic                  reset_n,
    pong_game_sequencer_if.slave bus
);
    localparam int unsigned SCORE_W = 4;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned SPD_W   = 4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_POINT = 3'd3,
        S_OVER  = 3'd4,
        S_PAUSE = 3'd5
    } state_t;

    state_t             r_state, w_nxt_state;
    logic [CNT_W-1:0]   r_cnt, w_nxt_cnt;
    logic [SPD_W-1:0]   r_spd, w_nxt_spd;
    logic [SCORE_W-1:0] r_score_l, w_nxt_score_l;
    logic [SCORE_W-1:0] r_score_r, w_nxt_score_r;
    logic               r_start_q;
    logic               r_ball_reset, w_nxt_ball_reset;
    logic               r_move_en, w_nxt_move_en;
    logic               r_serve_dir, w_nxt_serve_dir;
    logic               r_game_over, w_nxt_game_over;
    logic               r_winner, w_nxt_winner;
    logic               w_start_edge;
    logic               w_miss_any;
    logic               w_win_reached;

    assign w_start_edge  = bus.start_btn & ~r_start_q;
    assign w_miss_any    = bus.miss_left | bus.miss_right;
    assign w_win_reached = (r_score_l == SCORE_W'(WIN_SCORE)) ||
                           (r_score_r == SCORE_W'(WIN_SCORE));

`ifdef SEQ_PAUSE_EN
    logic r_pause_q;
    logic w_pause_edge;
    assign w_pause_edge = bus.pause_btn & ~r_pause_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_pause_q <= 1'b0;
        else          r_pause_q <= bus.pause_btn;
    end
`endif

    // Next-state and next-output logic; a frame tick in a transition cycle only feeds the old state's counter
    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_cnt       = r_cnt;
        w_nxt_spd       = r_spd;
        w_nxt_score_l   = r_score_l;
        w_nxt_score_r   = r_score_r;
        w_nxt_move_en   = 1'b0;
        w_nxt_serve_dir = r_serve_dir;
        w_nxt_game_over = r_game_over;
        w_nxt_winner    = r_winner;

        case (r_state)
            S_IDLE: begin
                if (w_start_edge) begin
                    w_nxt_score_l = '0;
                    w_nxt_score_r = '0;
                    w_nxt_cnt     = '0;
                    w_nxt_state   = S_SERVE;
                end
            end
            S_SERVE: begin
                if (bus.frame_tick) begin
                    if (r_cnt == CNT_W'(SERVE_FRAMES - 1)) begin
                        w_nxt_cnt   = '0;
                        w_nxt_state = S_PLAY;
                    end else begin
                        w_nxt_cnt = r_cnt + CNT_W'(1);
                    end
                end
            end
            S_PLAY: begin
                if (bus.frame_tick) begin
                    if (r_spd == SPD_W'(SPEED_DIV - 1)) begin
                        w_nxt_spd     = '0;
                        w_nxt_move_en = 1'b1;
                    end else begin
                        w_nxt_spd = r_spd + SPD_W'(1);
                    end
                end
                // A miss wins over a pending move; a double miss is a no-score replay
                if (w_miss_any) begin
                    w_nxt_move_en = 1'b0;
                    w_nxt_state   = S_POINT;
                    if (bus.miss_left && !bus.miss_right) begin
                        w_nxt_score_r   = r_score_r + SCORE_W'(1);
                        w_nxt_serve_dir = 1'b0;
                    end else if (bus.miss_right && !bus.miss_left) begin
                        w_nxt_score_l   = r_score_l + SCORE_W'(1);
                        w_nxt_serve_dir = 1'b1;
                    end
                end
`ifdef SEQ_PAUSE_EN
                else if (w_pause_edge) begin
                    w_nxt_move_en = 1'b0;
                    w_nxt_state   = S_PAUSE;
                end
`endif
            end
`ifdef SEQ_PAUSE_EN
            S_PAUSE: begin
                if (w_pause_edge) w_nxt_state = S_PLAY;
            end
`endif
            S_POINT: begin
                if (bus.frame_tick) begin
                    if (r_cnt == CNT_W'(POINT_FRAMES - 1)) begin
                        w_nxt_cnt = '0;
                        if (w_win_reached) begin
                            w_nxt_state     = S_OVER;
                            w_nxt_game_over = 1'b1;
                            w_nxt_winner    = (r_score_r == SCORE_W'(WIN_SCORE));
                        end else begin
                            w_nxt_state = S_SERVE;
                        end
                    end else begin
                        w_nxt_cnt = r_cnt + CNT_W'(1);
                    end
                end
            end
            S_OVER: begin
                if (w_start_edge) begin
                    w_nxt_score_l   = '0;
                    w_nxt_score_r   = '0;
                    w_nxt_game_over = 1'b0;
                    w_nxt_cnt       = '0;
                    w_nxt_state     = S_SERVE;
                end
            end
            default: w_nxt_state = S_IDLE;
        endcase

        w_nxt_ball_reset = !((w_nxt_state == S_PLAY) || (w_nxt_state == S_PAUSE));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_spd        <= '0;
            r_score_l    <= '0;
            r_score_r    <= '0;
            r_start_q    <= 1'b0;
            r_ball_reset <= 1'b1;
            r_move_en    <= 1'b0;
            r_serve_dir  <= 1'b0;
            r_game_over  <= 1'b0;
            r_winner     <= 1'b0;
        end else begin
            r_state      <= w_nxt_state;
            r_cnt        <= w_nxt_cnt;
            r_spd        <= w_nxt_spd;
            r_score_l    <= w_nxt_score_l;
            r_score_r    <= w_nxt_score_r;
            r_start_q    <= bus.start_btn;
            r_ball_reset <= w_nxt_ball_reset;
            r_move_en    <= w_nxt_move_en;
            r_serve_dir  <= w_nxt_serve_dir;
            r_game_over  <= w_nxt_game_over;
            r_winner     <= w_nxt_winner;
        end
    end

    assign bus.ball_reset  = r_ball_reset;
    assign bus.move_en     = r_move_en;
    assign bus.serve_dir   = r_serve_dir;
    assign bus.score_left  = r_score_l;
    assign bus.score_right = r_score_r;
    assign bus.game_over   = r_game_over;
    assign bus.winner      = r_winner;
    assign bus.seq_state   = r_state;
endmodule

// File: tb/tb_pong_game_sequencer.sv
// Bench for pong_game_sequencer: directed vector table, reset corner case and
// randomized play against a frame-counting reference model.
module tb_pong_game_sequencer;
    localparam int unsigned WIN   = 2;
    localparam int unsigned SERVE = 60;
    localparam int unsigned POINT = 30;
    localparam int unsigned DIV   = 2;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    pong_game_sequencer_if bus();

    pong_game_sequencer #(
        .WIN_SCORE   (WIN),
        .SERVE_FRAMES(SERVE),
        .POINT_FRAMES(POINT),
        .SPEED_DIV   (DIV)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: phase name, frames seen in the current hold, total play ticks
    int m_state, m_sl, m_sr, m_frames, m_play_ticks;
    int m_dir, m_move, m_over, m_win, m_start_prev;

    typedef struct {
        int tk, st, ml, mr, reps;
        int e_state, e_sl, e_sr, e_dir, e_move, e_over, e_win;
    } vec_t;
    vec_t tbl[23];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_sl = 0; m_sr = 0; m_frames = 0; m_play_ticks = 0;
        m_dir = 0; m_move = 0; m_over = 0; m_win = 0; m_start_prev = 0;
    endtask

    task automatic model_step(input int tk, input int st, input int ml, input int mr);
        int st_edge;
        st_edge = (st != 0 && m_start_prev == 0) ? 1 : 0;
        m_start_prev = st;
        m_move = 0;
        case (m_state)
            0: if (st_edge != 0) begin
                   m_sl = 0; m_sr = 0; m_frames = 0; m_state = 1;
               end
            1: if (tk != 0) begin
                   m_frames++;
                   if (m_frames == SERVE) begin m_frames = 0; m_state = 2; end
               end
            2: begin
                   if (tk != 0) begin
                       m_play_ticks++;
                       if (m_play_ticks % DIV == 0) m_move = 1;
                   end
                   if (ml != 0 || mr != 0) begin
                       m_move = 0;
                       m_state = 3;
                       if (ml != 0 && mr == 0) begin m_sr++; m_dir = 0; end
                       else if (mr != 0 && ml == 0) begin m_sl++; m_dir = 1; end
                   end
               end
            3: if (tk != 0) begin
                   m_frames++;
                   if (m_frames == POINT) begin
                       m_frames = 0;
                       if (m_sl == WIN || m_sr == WIN) begin
                           m_state = 4; m_over = 1; m_win = (m_sr == WIN) ? 1 : 0;
                       end else begin
                           m_state = 1;
                       end
                   end
               end
            default: if (st_edge != 0) begin
                   m_sl = 0; m_sr = 0; m_over = 0; m_frames = 0; m_state = 1;
               end
        endcase
    endtask

    task automatic check_model();
        chk("state",      int'(bus.seq_state),   m_state);
        chk("ball_reset", int'(bus.ball_reset),  (m_state == 2) ? 0 : 1);
        chk("move_en",    int'(bus.move_en),     m_move);
        chk("serve_dir",  int'(bus.serve_dir),   m_dir);
        chk("score_l",    int'(bus.score_left),  m_sl);
        chk("score_r",    int'(bus.score_right), m_sr);
        chk("game_over",  int'(bus.game_over),   m_over);
        if (m_over != 0) chk("winner", int'(bus.winner), m_win);
    endtask

    task automatic step(input int tk, input int st, input int ml, input int mr);
        bus.frame_tick = (tk != 0);
        bus.start_btn  = (st != 0);
        bus.miss_left  = (ml != 0);
        bus.miss_right = (mr != 0);
        @(posedge clk);
        model_step(tk, st, ml, mr);
        #1;
        check_model();
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_ball_reset", int'(bus.ball_reset),  1);
        chk("rst_state",      int'(bus.seq_state),   0);
        chk("rst_score_l",    int'(bus.score_left),  0);
        chk("rst_score_r",    int'(bus.score_right), 0);
        chk("rst_move_en",    int'(bus.move_en),     0);
        chk("rst_game_over",  int'(bus.game_over),   0);
        model_reset();
        bus.frame_tick = 1'b0; bus.start_btn = 1'b0;
        bus.miss_left  = 1'b0; bus.miss_right = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        check_model();
    endtask

    initial begin
        // tk st ml mr reps | state sl sr dir move over win
        tbl[0]  = '{0,0,0,0, 3, 0,0,0,0,0,0,0};
        tbl[1]  = '{0,1,0,0, 1, 1,0,0,0,0,0,0};
        tbl[2]  = '{1,0,0,0,59, 1,0,0,0,0,0,0};
        tbl[3]  = '{1,0,0,0, 1, 2,0,0,0,0,0,0};
        tbl[4]  = '{1,0,0,0, 1, 2,0,0,0,0,0,0};
        tbl[5]  = '{1,0,0,0, 1, 2,0,0,0,1,0,0};
        tbl[6]  = '{0,0,0,0, 1, 2,0,0,0,0,0,0};
        tbl[7]  = '{0,0,0,1, 1, 3,1,0,1,0,0,0};
        tbl[8]  = '{1,0,0,1,29, 3,1,0,1,0,0,0};
        tbl[9]  = '{1,0,0,0, 1, 1,1,0,1,0,0,0};
        tbl[10] = '{1,0,0,0,60, 2,1,0,1,0,0,0};
        tbl[11] = '{1,0,0,0, 1, 2,1,0,1,0,0,0};
        tbl[12] = '{1,0,1,1, 1, 3,1,0,1,0,0,0};
        tbl[13] = '{1,0,0,0,30, 1,1,0,1,0,0,0};
        tbl[14] = '{1,0,0,0,60, 2,1,0,1,0,0,0};
        tbl[15] = '{0,0,1,0, 1, 3,1,1,0,0,0,0};
        tbl[16] = '{1,0,0,0,30, 1,1,1,0,0,0,0};
        tbl[17] = '{1,0,0,0,60, 2,1,1,0,0,0,0};
        tbl[18] = '{0,0,1,0, 1, 3,1,2,0,0,0,0};
        tbl[19] = '{1,0,0,0,30, 4,1,2,0,0,1,1};
        tbl[20] = '{0,1,0,0, 3, 1,0,0,0,0,0,0};
        tbl[21] = '{0,0,0,0, 1, 1,0,0,0,0,0,0};
        tbl[22] = '{0,1,0,0, 1, 1,0,0,0,0,0,0};

        reset_n = 1'b0;
        bus.frame_tick = 1'b0; bus.start_btn = 1'b0;
        bus.miss_left  = 1'b0; bus.miss_right = 1'b0; bus.pause_btn = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("init_ball_reset", int'(bus.ball_reset),  1);
        chk("init_state",      int'(bus.seq_state),   0);
        chk("init_move_en",    int'(bus.move_en),     0);
        chk("init_serve_dir",  int'(bus.serve_dir),   0);
        chk("init_score_l",    int'(bus.score_left),  0);
        chk("init_score_r",    int'(bus.score_right), 0);
        chk("init_game_over",  int'(bus.game_over),   0);
        chk("init_winner",     int'(bus.winner),      0);
        reset_n = 1'b1;

        for (int i = 0; i < 23; i++) begin
            for (int r = 0; r < tbl[i].reps; r++)
                step(tbl[i].tk, tbl[i].st, tbl[i].ml, tbl[i].mr);
            chk($sformatf("vec%0d_state", i), int'(bus.seq_state),   tbl[i].e_state);
            chk($sformatf("vec%0d_sl", i),    int'(bus.score_left),  tbl[i].e_sl);
            chk($sformatf("vec%0d_sr", i),    int'(bus.score_right), tbl[i].e_sr);
            chk($sformatf("vec%0d_dir", i),   int'(bus.serve_dir),   tbl[i].e_dir);
            chk($sformatf("vec%0d_move", i),  int'(bus.move_en),     tbl[i].e_move);
            chk($sformatf("vec%0d_over", i),  int'(bus.game_over),   tbl[i].e_over);
            if (tbl[i].e_over != 0)
                chk($sformatf("vec%0d_win", i), int'(bus.winner), tbl[i].e_win);
        end

        // Reach PLAY at 1/1, then reset while a move_en pulse is being driven
        repeat (SERVE) step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        repeat (POINT) step(1, 0, 0, 0);
        repeat (SERVE) step(1, 0, 0, 0);
        step(0, 0, 0, 1);
        repeat (POINT) step(1, 0, 0, 0);
        repeat (SERVE) step(1, 0, 0, 0);
        chk("pre_rst_state", int'(bus.seq_state), 2);
        for (int k = 0; k < 8 && m_move == 0; k++) step(1, 0, 0, 0);
        chk("pre_rst_move", int'(bus.move_en), 1);
        chk("pre_rst_sl",   int'(bus.score_left), 1);
        chk("pre_rst_sr",   int'(bus.score_right), 1);
        apply_reset();

        for (int c = 0; c < 6000; c++) begin
            if (c == 3000) apply_reset();
            step(($urandom_range(0, 1) == 0) ? 1 : 0,
                 ($urandom_range(0, 39) == 0) ? 1 : 0,
                 ($urandom_range(0, 69) == 0) ? 1 : 0,
                 ($urandom_range(0, 69) == 0) ? 1 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
